// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver feeding a valid/ready byte queue with error pulses.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry circular buffer; otherwise a single holding register.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 173,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_ferr,
  output logic       o_overrun,
  output logic       o_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          busy_q, busy_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic          rx_s, push, pop;

  assign rx_s      = sync_q[1];
  assign o_ferr    = ferr_q;
  assign o_overrun = ovr_q;
  assign o_busy    = busy_q;

  always_comb begin
    sync_d  = {sync_q[0], i_rx};
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: if (cnt_q == HALF_END) begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == BIT_END) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == BIT_END) begin
        cnt_d   = '0;
        push    = rx_s;
        ferr_d  = !rx_s;
        state_d = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
    end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic        full;

  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign o_valid = wp_q != rp_q;
  assign o_data  = mem_q[rp_q[AW-1:0]];

  // A pop in the push cycle frees the slot, so a full queue still accepts the byte.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    pop   = o_valid && i_ready;
    ovr_d = push && full && !pop;
    if (push && !ovr_d) begin
      mem_d[wp_q[AW-1:0]] = shift_q;
      wp_d = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovr_q <= ovr_d;
    end
`else
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       unused_fifo_depth;

  assign unused_fifo_depth = |FIFO_DEPTH;
  assign o_valid = valid_q;
  assign o_data  = data_q;

  always_comb begin
    pop     = valid_q && i_ready;
    ovr_d   = push && valid_q && !pop;
    data_d  = (push && !ovr_d) ? shift_q : data_q;
    valid_d = (push && !ovr_d) || (valid_q && !pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames checked against a byte-queue reference model.
// Honours UART_RX_FIFO_EN to pick the expected queue capacity.
module tb_uart_rx_fifo;
  localparam int CPB   = 173;
  localparam int DEPTH = 4;
  localparam int HALF  = CPB / 2;
  localparam int LAT   = 2 + HALF + 9 * CPB + 1;
`ifdef UART_RX_FIFO_EN
  localparam int CAP       = DEPTH;
  localparam int BURST_OVR = 1;
`else
  localparam int CAP       = 1;
  localparam int BURST_OVR = 4;
`endif

  logic       i_clk, i_rst_n, i_rx, i_ready;
  logic [7:0] o_data;
  logic       o_valid, o_ferr, o_overrun, o_busy;

  int cyc, ferr_cnt, ovr_cnt, busy_cnt;
  int vectors, miscompares, exp_ferr, exp_ovr;
  int t0, lat, b0, npop;
  logic [7:0] mq [$];
  logic [7:0] burst [5];
  logic [7:0] rb;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_ferr(o_ferr), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_ferr) ferr_cnt <= ferr_cnt + 1;
    if (o_overrun) ovr_cnt <= ovr_cnt + 1;
    if (o_busy) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    repeat (90000) @(posedge i_clk);
    $display("FAIL watchdog: observed no finish, expected finish within 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    i_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CPB) @(negedge i_clk);
    end
    i_rx = stop;
    repeat (CPB) @(negedge i_clk);
    if (stop) i_rx = 1'b1;
  endtask

  task automatic pop();
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < CAP) mq.push_back(b);
    else exp_ovr++;
  endtask

  task automatic expect_head();
    logic [7:0] e;
    if (mq.size() == 0) check("empty_valid", o_valid, 0);
    else begin
      e = mq.pop_front();
      check("head_valid", o_valid, 1);
      check("head_data", o_data, e);
    end
    pop();
  endtask

  task automatic drain();
    while (mq.size() > 0) expect_head();
    check("drained", o_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_ferr"}, o_ferr, 0);
    check({tag, "_ovr"}, o_overrun, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    burst = '{8'h30, 8'h78, 8'h63, 8'h20, 8'h65};
    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    i_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // single byte: start-to-valid latency
    fork
      send_frame(8'h20, 1'b1);
      begin
        t0  = cyc;
        lat = -1;
        for (int k = 0; k < LAT + 100; k++) begin
          @(negedge i_clk);
          if (o_valid) begin
            lat = cyc - t0;
            break;
          end
        end
      end
    join
    check("latency", lat, LAT);
    mq.push_back(8'h20);
    expect_head();
    check("pop_clears", o_valid, 0);

    // burst with consumer stalled
    for (int i = 0; i < 5; i++) begin
      send_frame(burst[i], 1'b1);
      model_push(burst[i]);
    end
    repeat (2) @(negedge i_clk);
    check("burst_ovr", ovr_cnt, BURST_OVR);
    check("burst_ovr_model", ovr_cnt, exp_ovr);
    check("burst_head", o_data, 8'h30);
    drain();

    // framing error then held-low break
    send_frame(8'h55, 1'b0);
    exp_ferr++;
    repeat (3 * CPB) @(negedge i_clk);
    check("break_busy", o_busy, 1);
    check("ferr_once", ferr_cnt, exp_ferr);
    check("ferr_nopush", o_valid, 0);
    i_rx = 1'b1;
    repeat (4) @(negedge i_clk);
    check("break_exit", o_busy, 0);
    send_frame(8'h0A, 1'b1);
    model_push(8'h0A);
    drain();

    // glitch shorter than half a bit
    b0 = busy_cnt;
    i_rx = 1'b0;
    repeat (20) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (CPB) @(negedge i_clk);
    check("glitch_busy_seen", busy_cnt > b0, 1);
    check("glitch_idle", o_busy, 0);
    check("glitch_novalid", o_valid, 0);
    check("glitch_noferr", ferr_cnt, exp_ferr);

    // push and pop in the same cycle
    send_frame(8'h41, 1'b1);
    model_push(8'h41);
    fork
      send_frame(8'h42, 1'b1);
      begin
        repeat (LAT - 1) @(negedge i_clk);
        pop();
      end
    join
    void'(mq.pop_front());
    model_push(8'h42);
    check("simul_ovr", ovr_cnt, exp_ovr);
    drain();

    // reset in the middle of data bit 4
    send_frame(8'h77, 1'b1);
    model_push(8'h77);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (5 * CPB + HALF) @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("midreset");
        i_rst_n = 1'b1;
      end
    join
    mq.delete();
    check("midreset_empty", o_valid, 0);
    repeat (8 * CPB) @(negedge i_clk);
    for (int k = 0; k < 4; k++) if (o_valid) pop();
    check("flush_empty", o_valid, 0);
    check("midreset_ferr", ferr_cnt, exp_ferr);
    check("midreset_ovr", ovr_cnt, exp_ovr);
    send_frame(8'h31, 1'b1);
    model_push(8'h31);
    drain();

    // random bytes with random consumer pops between frames
    for (int n = 0; n < 5; n++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1);
      model_push(rb);
      check("rnd_ovr", ovr_cnt, exp_ovr);
      npop = int'($urandom_range(0, 2));
      repeat (npop) expect_head();
      repeat ($urandom_range(0, CPB)) @(negedge i_clk);
    end
    drain();
    check("final_ferr", ferr_cnt, exp_ferr);
    check("final_ovr", ovr_cnt, exp_ovr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Asynchronous serial receiver that sits directly upstream of the SoC's UART register interface. It takes the raw `i_uart_rx` pin, synchronises and samples it as 8N1 frames, and queues the received bytes for the CPU-side consumer behind a valid/ready handshake. It also reports framing errors and overruns as single-cycle pulses so the SoC can expose them in a status register.

## Interface
- `CLKS_PER_BIT`, 173 — clock cycles per serial bit; must be ≥ 8.
- `FIFO_DEPTH`, 4 — byte entries when the FIFO is compiled in; must be a power of two, ≥ 2.
- `i_clk`  in  1  single system clock; all logic on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_rx`  in  1  raw serial line; idles high; asynchronous to `i_clk`.
- `o_data`  out  8  head-of-queue byte; valid only while `o_valid`=1.
- `o_valid`  out  1  a byte is available.
- `i_ready`  in  1  consumer accepts `o_data` on a cycle where `o_valid` and `i_ready` are both 1.
- `o_ferr`  out  1  one-cycle pulse: stop bit sampled low.
- `o_overrun`  out  1  one-cycle pulse: a completed byte was dropped because the queue was full.
- `o_busy`  out  1  the receiver FSM is not in IDLE.

## Operation
- Input synchroniser: 2-flop chain. Both flops reset to 1. The FSM sees only the second flop, `rx_s`.
- Constant `HALF` = `CLKS_PER_BIT`/2, rounded down.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rx_s`=0, clear the bit counter and go to START.
  - START: after `HALF` cycles, re-sample `rx_s`. If it is 1, treat it as a glitch and return to IDLE with no error. If it is 0, go to DATA.
  - DATA: sample `rx_s` every `CLKS_PER_BIT` cycles, 8 times. Shift the samples in LSB first.
  - STOP: sample `rx_s` `CLKS_PER_BIT` cycles after the last data bit.
    - Sample = 1: push the byte and return to IDLE.
    - Sample = 0: pulse `o_ferr`, discard the byte, go to BREAK.
  - BREAK: wait until `rx_s`=1, then return to IDLE. This prevents a held-low line from retriggering reception.
- Queue rules:
  - Push and pop in the same cycle are both honoured, and occupancy is unchanged.
  - Push when full and no pop in that cycle: the byte is dropped and `o_overrun` pulses. Queue contents are unchanged.
  - Pop when empty is ignored.
  - Pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally. Full = MSBs differ and the rest are equal.
- `o_data`/`o_valid` come from registered queue state. There is no combinational path from `i_rx` or `i_ready` to any output.
- Reset mid-frame: the FSM goes to IDLE and the queue empties. If the line is still low after reset is released, the receiver treats it as a new start bit.

## Timing
- Reset values:
  - `o_valid`=0, `o_data`=0x00, `o_ferr`=0, `o_overrun`=0, `o_busy`=0.
  - Synchroniser flops = 1.
  - FSM = IDLE; queue pointers = 0.
- Start-to-valid latency, with the falling edge of `i_rx` at cycle 0:
  - `rx_s` goes low at cycle 2.
  - Stop bit is sampled at cycle 2 + `HALF` + 9·`CLKS_PER_BIT`.
  - `o_valid` rises one cycle after the stop-bit sample.
  - With the defaults this is cycle 1646.
- `o_ferr` and `o_overrun` assert in the cycle after the stop-bit sample, for exactly one cycle.
- After a pop, `o_valid`/`o_data` reflect the new head on the next cycle.
- Back-to-back frames: IDLE is re-entered at the stop-bit midpoint, so a start edge arriving half a bit later is caught.

## Configuration
- `UART_RX_FIFO_EN` defined: the queue is a `FIFO_DEPTH`-entry circular buffer, exactly as specified above.
- `UART_RX_FIFO_EN` undefined: the queue is a single holding register and `FIFO_DEPTH` is ignored.
  - Full = `o_valid`.
  - A push while `o_valid`=1 and `i_ready`=0 drops the new byte and pulses `o_overrun`.
  - A push in the same cycle as a pop is accepted.

## Test plan
- Single byte: send 0x20 at 173 cycles/bit with `i_ready`=0.
  - Expect `o_valid`=1 at cycle 1646 after the start edge, with `o_data`=0x20.
  - Assert `i_ready` for one cycle; `o_valid`=0 on the next cycle.
- Burst with consumer stalled: send "0", "x", "c", " ", "e" back-to-back with `i_ready`=0.
  - FIFO build: reading drains 0x30, 0x78, 0x63, 0x20 in order, and one `o_overrun` pulse occurs on the 5th byte.
  - Non-FIFO build: `o_data` holds 0x30, and four `o_overrun` pulses occur.
- Framing error: send 0x55 with the stop bit driven low, then hold the line low for 3 bit times, then release.
  - Expect one `o_ferr` pulse, no push, and `o_busy`=1 until the line returns high.
  - A following 0x0A frame is received correctly.
- Glitch: pulse `i_rx` low for 20 cycles.
  - Expect `o_busy` to rise and then return to 0, with no `o_valid` and no `o_ferr`.
- Simultaneous push and pop: FIFO holds 1 byte and `i_ready`=1 in the push cycle.
  - Expect occupancy to stay at 1, with the new byte at the head next.
- Reset mid-frame: assert `i_rst_n`=0 during data bit 4 of 0xA5.
  - Expect all outputs to equal their reset values and the queue to be empty.
  - The next full frame 0x31 is received correctly.
